spi_master: RTL and testbench

- SPI master that transfers one m-bit word full-duplex per frame, MSB first, mode 0 (CPOL=0, CPHA=0).
- SCLK idles low. MOSI changes only after SCLK falling edges. MISO is sampled on SCLK rising edges. SS is active low.
- It is the initiator end of the team's SPI link and drives SPI_SLAVE on the far side.
- The full design uses a single clock domain, GCLK, so SCLK is a registered, divided output.

---
 rtl/spi_defs.sv | 27 ++
 rtl/spi_sclk_gen.sv | 59 +++++
 rtl/spi_master.sv | 130 +++++++++++++
 tb/tb_spi_master.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_defs.sv
// Shared SPI definitions: FSM state encoding, link mode constants and a
// small elaboration-time helper used to size the phase timer.
package spi_defs;

    // Link mode: SCLK idles low, data sampled on rising edges, MSB first.
    localparam logic CPOL      = 1'b0;
    localparam logic CPHA      = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TRAIL,
        S_GAP
    } spi_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int r;
        r = a;
        if (b > r) r = b;
        if (c > r) r = c;
        return r;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Phase timer and bit counter for the SPI master. The timer is loaded with
// a start value, counts down while enabled and, on expiry, alternates
// between "rise" and "fall" events, reloading DIV-1 each time. The bit
// counter advances on every fall so the FSM knows when the last bit is out.
module spi_sclk_gen
    import spi_defs::*;
#(
    parameter int m   = 15,
    parameter int DIV = 2,
    parameter int TW  = 2
)(
    input  logic          GCLK,
    input  logic          RST,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          enable,
    output logic          rise_evt,
    output logic          fall_evt,
    output logic          last_bit
);

    localparam int            BW         = (m > 1) ? $clog2(m) : 1;
    localparam logic [BW-1:0] LAST_INDEX = BW'(m - 1);
    localparam logic [TW-1:0] DIV_RELOAD = TW'(DIV - 1);

    logic [TW-1:0] timer;
    logic [BW-1:0] bit_cnt;
    logic          phase_hi;
    logic          expired;

    assign expired  = enable && (timer == '0);
    assign rise_evt = expired && !phase_hi;
    assign fall_evt = expired && phase_hi;
    assign last_bit = (bit_cnt == LAST_INDEX);

    // Count down the current phase; on expiry flip phase and reload one half-period.
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            timer    <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
        end else if (load) begin
            timer    <= load_val;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
        end else if (enable) begin
            if (timer != '0) begin
                timer <= timer - 1'b1;
            end else begin
                timer    <= DIV_RELOAD;
                phase_hi <= !phase_hi;
                if (phase_hi && (bit_cnt != LAST_INDEX)) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first, one m-bit full-duplex word per frame.
// SCLK, SS and MOSI are all driven straight from flops. The sub-module
// supplies timing events; the FSM and the shift registers live here. The
// same timer is reused for the SS setup lead-in and the inter-frame gap.
module spi_master
    import spi_defs::*;
#(
    parameter int m     = 15,
    parameter int DIV   = 2,
    parameter int SETUP = 2,
    parameter int GAP   = 2
)(
    input  logic         GCLK,
    input  logic         RST,
    input  logic         START,
    input  logic [m-1:0] DIN,
    output logic [m-1:0] DOUT,
    output logic         DONE,
    output logic         BUSY,
    output logic         SCLK,
    output logic         MOSI,
    input  logic         MISO,
    output logic         SS
);

    localparam int            TMAX          = max3(SETUP - 1, DIV - 1, GAP - 1);
    localparam int            TW            = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
    localparam logic [TW-1:0] SETUP_RELOAD  = TW'(SETUP - 1);
    localparam logic [TW-1:0] GAP_RELOAD    = TW'(GAP - 1);

    spi_state_t    state;
    logic [m-1:0]  tx_sr;
    logic [m-1:0]  rx_sr;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          rise_evt;
    logic          fall_evt;
    logic          last_bit;

    // In IDLE with BUSY set we are in the launch cycle after acceptance, so
    // the timer is primed for the SS lead-in; at the end of TRAIL it is
    // primed for the gap. A rise event in TRAIL/GAP simply means "expired".
    assign tmr_load = ((state == S_IDLE) && BUSY) || ((state == S_TRAIL) && rise_evt);
    assign tmr_val  = (state == S_IDLE) ? SETUP_RELOAD : GAP_RELOAD;
    assign tmr_en   = (state != S_IDLE);

    spi_sclk_gen #(
        .m   (m),
        .DIV (DIV),
        .TW  (TW)
    ) u_sclk_gen (
        .GCLK     (GCLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .enable   (tmr_en),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt),
        .last_bit (last_bit)
    );

    // Frame sequencer: drives the serial pins, shift registers and handshake outputs.
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            tx_sr <= '0;
            rx_sr <= '0;
            DOUT  <= '0;
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
            SCLK  <= CPOL;
            MOSI  <= 1'b0;
            SS    <= 1'b1;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (BUSY) begin
                        SS    <= 1'b0;
                        MOSI  <= tx_sr[m-1];
                        state <= S_LEAD;
                    end else if (START) begin
                        tx_sr <= DIN;
                        rx_sr <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                S_LEAD, S_LOW: begin
                    if (rise_evt) begin
                        SCLK  <= 1'b1;
                        rx_sr <= {rx_sr[m-2:0], MISO};
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (fall_evt) begin
                        SCLK <= CPOL;
                        if (last_bit) begin
                            state <= S_TRAIL;
                        end else begin
                            tx_sr <= {tx_sr[m-2:0], 1'b0};
                            MOSI  <= tx_sr[m-2];
                            state <= S_LOW;
                        end
                    end
                end
                S_TRAIL: begin
                    if (rise_evt) begin
                        SS    <= 1'b1;
                        MOSI  <= 1'b0;
                        DOUT  <= rx_sr;
                        DONE  <= 1'b1;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (rise_evt) begin
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master. Two instances share GCLK/RST: index 0
// uses the default timing, index 1 uses DIV=1. A behavioural SPI slave
// answers each master; expected frames go into a scoreboard when stimulus
// is issued and a monitor pops and compares them whenever DONE pulses.
module tb_spi_master;

    localparam int M     = 15;
    localparam int DIV0  = 2;
    localparam int SETUP = 2;
    localparam int GAPC  = 2;

    typedef struct {
        int           inst;
        logic [M-1:0] din;
        logic [M-1:0] sword;
        int           t0;
    } frame_t;

    logic         GCLK;
    logic         RST;
    logic         start_v [2];
    logic [M-1:0] din_v   [2];
    logic [M-1:0] dout_v  [2];
    logic         done_v  [2];
    logic         busy_v  [2];
    logic         sclk_v  [2];
    logic         mosi_v  [2];
    logic         miso_v  [2];
    logic         ss_v    [2];

    frame_t       sb[$];
    frame_t       mon_e;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    logic [M-1:0] slave_word [2];
    logic [M-1:0] slv_tx     [2];
    logic [M-1:0] slv_rx     [2];
    logic [M-1:0] slv_dout   [2];
    logic         prev_ss    [2];
    logic         prev_sclk  [2];
    logic         prev_mosi  [2];
    logic         prev_busy  [2];
    logic         done_chk   [2];
    int           rises      [2];
    int           first_rise [2];
    int           last_rise  [2];
    int           ss_rise_cyc[2];
    int           shape_viol [2];
    int           mosi_viol  [2];
    int           exp_busy_fall [2];
    int           frames_started [2];
    int           free_at    [2];

    spi_master #(.m(M), .DIV(DIV0), .SETUP(SETUP), .GAP(GAPC)) dut (
        .GCLK(GCLK), .RST(RST), .START(start_v[0]), .DIN(din_v[0]),
        .DOUT(dout_v[0]), .DONE(done_v[0]), .BUSY(busy_v[0]),
        .SCLK(sclk_v[0]), .MOSI(mosi_v[0]), .MISO(miso_v[0]), .SS(ss_v[0])
    );

    spi_master #(.m(M), .DIV(1), .SETUP(SETUP), .GAP(GAPC)) dut_d1 (
        .GCLK(GCLK), .RST(RST), .START(start_v[1]), .DIN(din_v[1]),
        .DOUT(dout_v[1]), .DONE(done_v[1]), .BUSY(busy_v[1]),
        .SCLK(sclk_v[1]), .MOSI(mosi_v[1]), .MISO(miso_v[1]), .SS(ss_v[1])
    );

    initial begin
        GCLK = 1'b0;
        forever #5 GCLK = ~GCLK;
    end

    always @(posedge GCLK) cyc = cyc + 1;

    function automatic int divOf(input int i);
        return (i == 0) ? DIV0 : 1;
    endfunction

    // Cycles from START acceptance to the edge that raises SS and pulses DONE.
    function automatic int flen(input int i);
        return 1 + SETUP + 2 * M * divOf(i);
    endfunction

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s[%0d] at cycle %0d: got %0h expected %0h",
                     name, inst, cyc, act, exp);
        end
    endtask

    // Issue one START pulse once the model says the master is idle again.
    task automatic applyStimulus(input int inst, input logic [M-1:0] d,
                                 input logic [M-1:0] sw);
        frame_t e;
        @(posedge GCLK); #2;
        while (cyc < free_at[inst]) begin
            @(posedge GCLK); #2;
        end
        start_v[inst]    = 1'b1;
        din_v[inst]      = d;
        slave_word[inst] = sw;
        e.inst  = inst;
        e.din   = d;
        e.sword = sw;
        e.t0    = cyc + 1;
        sb.push_back(e);
        free_at[inst] = e.t0 + flen(inst) + GAPC;
        @(posedge GCLK); #2;
        start_v[inst] = 1'b0;
        din_v[inst]   = M'($urandom);
    endtask

    task automatic waitDrain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(posedge GCLK);
            g++;
        end
        checkOutput("drain", 0, sb.size(), 0);
        repeat (GAPC + 3) @(posedge GCLK);
    endtask

    // Behavioural slave plus protocol monitor, evaluated away from the active edge.
    always @(negedge GCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!ss_v[i] && prev_ss[i]) begin
                slv_tx[i]  = slave_word[i];
                slv_rx[i]  = '0;
                miso_v[i]  = slv_tx[i][M-1];
                frames_started[i]++;
                rises[i]      = 0;
                first_rise[i] = -1;
                shape_viol[i] = 0;
                mosi_viol[i]  = 0;
                if (sb.size() > 0) checkOutput("ss_fall_time", i, cyc, sb[0].t0 + 1);
            end else if (!ss_v[i] && prev_sclk[i] && !sclk_v[i]) begin
                slv_tx[i] = slv_tx[i] << 1;
                miso_v[i] = slv_tx[i][M-1];
                if (cyc - last_rise[i] != divOf(i)) shape_viol[i]++;
            end
            if (ss_v[i] && !prev_ss[i]) begin
                slv_dout[i]    = slv_rx[i];
                ss_rise_cyc[i] = cyc;
                miso_v[i]      = 1'b0;
            end
            if (sclk_v[i] && !prev_sclk[i]) begin
                slv_rx[i] = {slv_rx[i][M-2:0], mosi_v[i]};
                if (rises[i] == 0) first_rise[i] = cyc;
                else if (cyc - last_rise[i] != 2 * divOf(i)) shape_viol[i]++;
                last_rise[i] = cyc;
                rises[i]++;
            end
            if (sclk_v[i] && (mosi_v[i] != prev_mosi[i])) mosi_viol[i]++;

            if (done_chk[i]) begin
                checkOutput("done_width", i, done_v[i], 0);
                done_chk[i] = 1'b0;
            end
            if (done_v[i]) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", i, 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("frame_inst",   i, i, mon_e.inst);
                    checkOutput("dout",         i, dout_v[i], mon_e.sword);
                    checkOutput("slave_rx",     i, slv_dout[i], mon_e.din);
                    checkOutput("done_time",    i, cyc, mon_e.t0 + flen(i));
                    checkOutput("ss_rise_time", i, ss_rise_cyc[i], mon_e.t0 + flen(i));
                    checkOutput("first_rise",   i, first_rise[i], mon_e.t0 + 1 + SETUP);
                    checkOutput("rise_count",   i, rises[i], M);
                    checkOutput("sclk_shape",   i, shape_viol[i], 0);
                    checkOutput("mosi_stable",  i, mosi_viol[i], 0);
                    checkOutput("busy_at_done", i, busy_v[i], 1);
                    exp_busy_fall[i] = mon_e.t0 + flen(i) + GAPC;
                    done_chk[i] = 1'b1;
                end
            end
            if (!busy_v[i] && prev_busy[i] && exp_busy_fall[i] != 0) begin
                checkOutput("busy_fall_time", i, cyc, exp_busy_fall[i]);
                exp_busy_fall[i] = 0;
            end
            prev_ss[i]   = ss_v[i];
            prev_sclk[i] = sclk_v[i];
            prev_mosi[i] = mosi_v[i];
            prev_busy[i] = busy_v[i];
        end
    end

    initial begin
        int bad;
        int guard;
        int next_acc;
        int nfr;
        int fs0;
        frame_t e;

        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;  din_v[i] = '0;   miso_v[i] = 1'b0;
            slave_word[i] = '0; slv_tx[i] = '0;  slv_rx[i] = '0; slv_dout[i] = '0;
            prev_ss[i] = 1'b1;  prev_sclk[i] = 1'b0; prev_mosi[i] = 1'b0;
            prev_busy[i] = 1'b0; done_chk[i] = 1'b0;
            rises[i] = 0; first_rise[i] = -1; last_rise[i] = 0; ss_rise_cyc[i] = 0;
            shape_viol[i] = 0; mosi_viol[i] = 0; exp_busy_fall[i] = 0;
            frames_started[i] = 0; free_at[i] = 0;
        end

        // Reset values must appear with no clock edge.
        RST = 1'b1;
        #1;
        checkOutput("rst_ss",   0, ss_v[0], 1);
        checkOutput("rst_sclk", 0, sclk_v[0], 0);
        checkOutput("rst_mosi", 0, mosi_v[0], 0);
        checkOutput("rst_busy", 0, busy_v[0], 0);
        checkOutput("rst_dout", 0, dout_v[0], 0);
        checkOutput("rst_done", 0, done_v[0], 0);
        repeat (3) @(posedge GCLK);
        #2 RST = 1'b0;

        // Idle for 100 cycles with no START.
        bad = 0;
        repeat (100) begin
            @(negedge GCLK);
            for (int i = 0; i < 2; i++)
                if (ss_v[i] !== 1'b1 || sclk_v[i] !== 1'b0 || mosi_v[i] !== 1'b0 ||
                    busy_v[i] !== 1'b0 || dout_v[i] !== '0 || done_v[i] !== 1'b0) bad++;
        end
        checkOutput("idle_100", 0, bad, 0);

        $display("[TB] loopback and edge patterns");
        applyStimulus(0, 15'h7001, 15'h2A5A);
        applyStimulus(0, 15'h7FFF, 15'h0000);
        applyStimulus(0, 15'h0000, 15'h7FFF);
        for (int k = 0; k < 6; k++) applyStimulus(0, M'($urandom), M'($urandom));
        waitDrain();

        // START held high: frames every flen+GAP+1 cycles, DIN taken at each acceptance.
        $display("[TB] START held high");
        @(posedge GCLK); #2;
        while (cyc < free_at[0]) begin
            @(posedge GCLK); #2;
        end
        start_v[0] = 1'b1;
        din_v[0]   = M'($urandom);
        next_acc   = cyc + 1;
        nfr = 0;
        guard = 0;
        while (nfr < 3 && guard < 400) begin
            @(posedge GCLK); #2;
            guard++;
            if (cyc == next_acc) begin
                slave_word[0] = M'($urandom);
                e.inst = 0; e.din = din_v[0]; e.sword = slave_word[0]; e.t0 = cyc;
                sb.push_back(e);
                nfr++;
                next_acc = cyc + flen(0) + GAPC + 1;
                if (nfr == 3) begin
                    start_v[0] = 1'b0;
                    free_at[0] = cyc + flen(0) + GAPC;
                end
            end
            din_v[0] = M'($urandom);
        end
        start_v[0] = 1'b0;
        waitDrain();

        // Asynchronous reset in the middle of a frame, then a clean frame.
        $display("[TB] reset mid-frame");
        fs0 = frames_started[0];
        applyStimulus(0, M'($urandom), M'($urandom));
        guard = 0;
        while (!(frames_started[0] == fs0 + 1 && rises[0] >= 7) && guard < 300) begin
            @(posedge GCLK);
            guard++;
        end
        checkOutput("reach_rise7", 0, (rises[0] >= 7), 1);
        #3 RST = 1'b1;
        #1;
        checkOutput("mid_rst_ss",   0, ss_v[0], 1);
        checkOutput("mid_rst_sclk", 0, sclk_v[0], 0);
        checkOutput("mid_rst_busy", 0, busy_v[0], 0);
        checkOutput("mid_rst_dout", 0, dout_v[0], 0);
        checkOutput("mid_rst_done", 0, done_v[0], 0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(posedge GCLK); #2;
        RST = 1'b0;
        free_at[0] = cyc;
        applyStimulus(0, 15'h1234, 15'h4321);
        waitDrain();

        $display("[TB] DIV=1 instance");
        applyStimulus(1, 15'h7001, 15'h2A5A);
        for (int k = 0; k < 3; k++) applyStimulus(1, M'($urandom), M'($urandom));
        waitDrain();

        checkOutput("busy_fall_pending", 0, exp_busy_fall[0], 0);
        checkOutput("busy_fall_pending", 1, exp_busy_fall[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
